gcn_result_streamer: RTL

- Downstream stage of the GCN top. Captures the per-node argmax vector (max_addi_answer) when the max stage signals done.
- Streams the captured vector out one node per beat over a valid/ready interface, so the per-node results can cross to a narrow host or scan port.
- Double-buffered capture: the GCN can start the next graph while the previous result is still draining.

---
 rtl/gcn_stream_pkg.sv | 17 +
 rtl/gcn_result_buffer.sv | 94 +++++++++
 rtl/gcn_result_streamer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/gcn_stream_pkg.sv
// Shared types and constants for the GCN result streamer and the GCN top.
package gcn_stream_pkg;

  localparam int unsigned FEATURE_ROWS      = 6;
  localparam int unsigned NUM_CLASSES       = 3;
  localparam int unsigned MAX_ADDRESS_WIDTH = 2;
  localparam int unsigned NODE_ID_WIDTH     = $clog2(FEATURE_ROWS);

  typedef logic [MAX_ADDRESS_WIDTH-1:0] class_t;
  typedef logic [NODE_ID_WIDTH-1:0]     node_id_t;

  typedef enum logic [0:0] {
    IDLE,
    STREAM
  } state_t;

endpackage

// File: rtl/gcn_result_buffer.sv
// Two-slot capture buffer: active slot A feeds the stream, pending slot P waits behind it.
// GCN_RESULT_HIST_EN exposes the vector being loaded into A for the histogram.
module gcn_result_buffer #(
  parameter int unsigned FEATURE_ROWS      = 6,
  parameter int unsigned MAX_ADDRESS_WIDTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         capture_i,
  input  logic [MAX_ADDRESS_WIDTH-1:0] data_i [0:FEATURE_ROWS-1],
  input  logic                         free_i,
  output logic [MAX_ADDRESS_WIDTH-1:0] a_data_o [0:FEATURE_ROWS-1],
  output logic                         a_full_o,
  output logic                         p_full_o,
  output logic                         drop_o,
  output logic                         load_a_o
`ifdef GCN_RESULT_HIST_EN
  ,
  output logic [MAX_ADDRESS_WIDTH-1:0] load_data_o [0:FEATURE_ROWS-1]
`endif
);

  import gcn_stream_pkg::*;

  logic [MAX_ADDRESS_WIDTH-1:0] a_q [0:FEATURE_ROWS-1];
  logic [MAX_ADDRESS_WIDTH-1:0] a_d [0:FEATURE_ROWS-1];
  logic [MAX_ADDRESS_WIDTH-1:0] p_q [0:FEATURE_ROWS-1];
  logic [MAX_ADDRESS_WIDTH-1:0] p_d [0:FEATURE_ROWS-1];
  logic                         a_full_q, a_full_d;
  logic                         p_full_q, p_full_d;

  always_comb begin
    a_d      = a_q;
    p_d      = p_q;
    a_full_d = a_full_q;
    p_full_d = p_full_q;
    drop_o   = 1'b0;
    load_a_o = 1'b0;
    if (free_i) begin
      // A drains this cycle: promote P, and a coincident capture always finds a free slot.
      if (p_full_q) begin
        a_d      = p_q;
        a_full_d = 1'b1;
        load_a_o = 1'b1;
        if (capture_i) begin
          p_d      = data_i;
          p_full_d = 1'b1;
        end else begin
          p_full_d = 1'b0;
        end
      end else if (capture_i) begin
        a_d      = data_i;
        a_full_d = 1'b1;
        load_a_o = 1'b1;
      end else begin
        a_full_d = 1'b0;
      end
    end else if (capture_i) begin
      if (!a_full_q) begin
        a_d      = data_i;
        a_full_d = 1'b1;
        load_a_o = 1'b1;
      end else if (!p_full_q) begin
        p_d      = data_i;
        p_full_d = 1'b1;
      end else begin
        drop_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q      <= '{default: '0};
      p_q      <= '{default: '0};
      a_full_q <= 1'b0;
      p_full_q <= 1'b0;
    end else begin
      a_q      <= a_d;
      p_q      <= p_d;
      a_full_q <= a_full_d;
      p_full_q <= p_full_d;
    end
  end

  assign a_data_o = a_q;
  assign a_full_o = a_full_q;
  assign p_full_o = p_full_q;

`ifdef GCN_RESULT_HIST_EN
  assign load_data_o = a_d;
`endif

endmodule

// File: rtl/gcn_result_streamer.sv
// Captures the GCN argmax vector on done's rising edge and streams it one node per beat.
// Define GCN_RESULT_HIST_EN to add the per-class histogram output class_hist.
module gcn_result_streamer #(
  parameter int unsigned FEATURE_ROWS      = 6,
  parameter int unsigned MAX_ADDRESS_WIDTH = 2,
  parameter int unsigned NODE_ID_WIDTH     = $clog2(FEATURE_ROWS)
`ifdef GCN_RESULT_HIST_EN
  ,
  parameter int unsigned NUM_CLASSES       = 3
`endif
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         done,
  input  logic [MAX_ADDRESS_WIDTH-1:0] max_addi_answer [0:FEATURE_ROWS-1],
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NODE_ID_WIDTH-1:0]     out_node_id,
  output logic [MAX_ADDRESS_WIDTH-1:0] out_class,
  output logic                         out_last,
  output logic                         stream_done,
  output logic                         busy,
  output logic                         overrun,
  input  logic                         clear_overrun
`ifdef GCN_RESULT_HIST_EN
  ,
  output logic [NODE_ID_WIDTH:0]       class_hist [0:NUM_CLASSES-1]
`endif
);

  import gcn_stream_pkg::*;

  localparam logic [NODE_ID_WIDTH-1:0] LastNode = NODE_ID_WIDTH'(FEATURE_ROWS - 1);

  logic                         done_q;
  logic                         capture;
  logic                         final_hs;
  logic                         last_node;
  logic [MAX_ADDRESS_WIDTH-1:0] a_data [0:FEATURE_ROWS-1];
  logic                         a_full, p_full, drop, load_a;

  state_t                       state_q, state_d;
  logic [NODE_ID_WIDTH-1:0]     node_cnt_q, node_cnt_d;
  logic                         stream_done_q;
  logic                         overrun_q, overrun_d;

`ifdef GCN_RESULT_HIST_EN
  logic [MAX_ADDRESS_WIDTH-1:0] load_data [0:FEATURE_ROWS-1];
  logic [NODE_ID_WIDTH:0]       hist_q [0:NUM_CLASSES-1];
  logic [NODE_ID_WIDTH:0]       hist_d [0:NUM_CLASSES-1];
`endif

  assign capture   = done & ~done_q;
  assign out_valid = (state_q == STREAM);
  assign last_node = (node_cnt_q == LastNode);
  assign final_hs  = out_valid & out_ready & last_node;

  gcn_result_buffer #(
    .FEATURE_ROWS      (FEATURE_ROWS),
    .MAX_ADDRESS_WIDTH (MAX_ADDRESS_WIDTH)
  ) u_buffer (
    .clk_i       (clk),
    .rst_ni      (reset),
    .capture_i   (capture),
    .data_i      (max_addi_answer),
    .free_i      (final_hs),
    .a_data_o    (a_data),
    .a_full_o    (a_full),
    .p_full_o    (p_full),
    .drop_o      (drop),
    .load_a_o    (load_a)
`ifdef GCN_RESULT_HIST_EN
    ,
    .load_data_o (load_data)
`endif
  );

  always_comb begin
    state_d    = state_q;
    node_cnt_d = node_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (load_a) begin
          state_d    = STREAM;
          node_cnt_d = '0;
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (last_node) begin
            // A reload on the final beat keeps streaming without a bubble.
            if (load_a) begin
              node_cnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            node_cnt_d = node_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    overrun_d = overrun_q;
    if (drop) begin
      overrun_d = 1'b1;
    end else if (clear_overrun) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_q        <= 1'b0;
      state_q       <= IDLE;
      node_cnt_q    <= '0;
      stream_done_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      done_q        <= done;
      state_q       <= state_d;
      node_cnt_q    <= node_cnt_d;
      stream_done_q <= final_hs;
      overrun_q     <= overrun_d;
    end
  end

  assign out_node_id = out_valid ? node_cnt_q : '0;
  assign out_class   = out_valid ? a_data[node_cnt_q] : '0;
  assign out_last    = out_valid & last_node;
  assign stream_done = stream_done_q;
  assign busy        = a_full | p_full;
  assign overrun     = overrun_q;

`ifdef GCN_RESULT_HIST_EN
  always_comb begin
    hist_d = hist_q;
    if (load_a) begin
      for (int unsigned c = 0; c < NUM_CLASSES; c++) begin
        hist_d[c] = '0;
        for (int unsigned n = 0; n < FEATURE_ROWS; n++) begin
          if (32'(load_data[n]) == c) begin
            hist_d[c] = hist_d[c] + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q <= '{default: '0};
    end else begin
      hist_q <= hist_d;
    end
  end

  assign class_hist = hist_q;
`endif

endmodule
